// File: rtl/pc_sequencer.sv
// Program counter register and next-PC sequencer: jr > jump > branch > PC+4 selection,
// with stall, halt/resume, a one-cycle flush after each redirect and a saturating redirect count.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             branch,
  input  logic             jump,
  input  logic             jr,
  input  logic [31:0]      branch_dst,
  input  logic [31:0]      jump_dst,
  input  logic [31:0]      jr_dst,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               flush_q, flush_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               redirect;
  logic [31:0]        target;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = jr | jump | branch;

  always_comb begin
    target = jr ? jr_dst : (jump ? jump_dst : branch_dst);
    // Targets are word aligned; drop any stray byte offset.
    target[1:0] = 2'b00;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (redirect) begin
          pc_d    = target;
          flush_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!stall) begin
          pc_d = pc_plus4;
        end
        if (halt_req) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (resume) begin
          state_d = StRun;
          if (!stall) begin
            pc_d = pc_plus4;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign flush        = flush_q;
  assign halted       = (state_q == StHalt);
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance with a 2-bit counter covers saturation.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic        branch = 1'b0, jump = 1'b0, jr = 1'b0;
  logic [31:0] branch_dst = '0, jump_dst = '0, jr_dst = '0;
  logic [31:0] pc, pc_plus4, pc_s, pc_plus4_s;
  logic        flush, halted, flush_s, halted_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .resume(resume),
    .branch(branch), .jump(jump), .jr(jr), .branch_dst(branch_dst), .jump_dst(jump_dst),
    .jr_dst(jr_dst), .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .halted(halted),
    .redirect_cnt(cnt)
  );

  pc_sequencer #(.RESET_PC(32'h0), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .resume(resume),
    .branch(branch), .jump(jump), .jr(jr), .branch_dst(branch_dst), .jump_dst(jump_dst),
    .jr_dst(jr_dst), .pc(pc_s), .pc_plus4(pc_plus4_s), .flush(flush_s), .halted(halted_s),
    .redirect_cnt(cnt_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; halt_req = 0; resume = 0; branch = 0; jump = 0; jr = 0;
  endtask

  task automatic test_reset();
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (pc !== 32'(i * 4)) begin
        errors++; $display("FAIL idle_pc%0d got %h exp %h", i, pc, 32'(i * 4));
      end
    end
  endtask

  task automatic test_branch();
    step();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL pre_branch_pc got %h exp 10", pc); end
    branch = 1; branch_dst = 32'h40;
    step();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_pc got %h exp 40", pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL branch_flush got %b exp 1", flush); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL branch_cnt got %0d exp 1", cnt); end
    branch = 0;
    step();
    checks++; if (pc !== 32'h44) begin errors++; $display("FAIL post_branch_pc got %h exp 44", pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL post_branch_flush got %b exp 0", flush); end
  endtask

  task automatic test_priority();
    jr = 1; jump = 1; branch = 1; jr_dst = 32'h100; jump_dst = 32'h200; branch_dst = 32'h300;
    step();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL prio_jr got %h exp 100", pc); end
    jr = 0;
    step();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL prio_jump got %h exp 200", pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush got %b exp 1", flush); end
    jr = 1; jump = 0; branch = 0; jr_dst = 32'h103;
    step();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jr_align got %h exp 100", pc); end
    checks++; if (cnt !== 16'd4) begin errors++; $display("FAIL prio_cnt got %0d exp 4", cnt); end
    clear_inputs();
    step();
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL post_prio_pc got %h exp 104", pc); end
    checks++; if (pc_plus4 !== 32'h108) begin errors++; $display("FAIL pc_plus4 got %h exp 108", pc_plus4); end
  endtask

  task automatic test_stall();
    jump = 1; jump_dst = 32'h20;
    step();
    jump = 0; stall = 1;
    step();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL stall1_pc got %h exp 20", pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL stall_flush got %b exp 0", flush); end
    step();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL stall2_pc got %h exp 20", pc); end
    jump = 1; jump_dst = 32'h80;
    step();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL stall_jump_pc got %h exp 80", pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_jump_flush got %b exp 1", flush); end
    checks++; if (cnt !== 16'd6) begin errors++; $display("FAIL stall_cnt got %0d exp 6", cnt); end
    clear_inputs();
  endtask

  task automatic test_halt_resume();
    jump = 1; jump_dst = 32'h30;
    step();
    jump = 0; halt_req = 1;
    step();
    checks++; if (pc !== 32'h34) begin errors++; $display("FAIL halt_pc got %h exp 34", pc); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got %b exp 1", halted); end
    halt_req = 0; jump = 1; jump_dst = 32'h300;
    step();
    checks++; if (pc !== 32'h34) begin errors++; $display("FAIL halt_jump_pc got %h exp 34", pc); end
    checks++; if (cnt !== 16'd7) begin errors++; $display("FAIL halt_cnt got %0d exp 7", cnt); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL halt_flush got %b exp 0", flush); end
    jump = 0; resume = 1;
    step();
    checks++; if (pc !== 32'h38) begin errors++; $display("FAIL resume_pc got %h exp 38", pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume_halted got %b exp 0", halted); end
    resume = 0; halt_req = 1;
    step();
    halt_req = 0; resume = 1; stall = 1;
    step();
    checks++; if (pc !== 32'h3C) begin errors++; $display("FAIL resume_stall_pc got %h exp 3c", pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume_stall_halted got %b exp 0", halted); end
    clear_inputs();
    halt_req = 1; jump = 1; jump_dst = 32'h50;
    step();
    checks++; if (pc !== 32'h50) begin errors++; $display("FAIL halt_redirect_pc got %h exp 50", pc); end
    checks++; if (flush !== 1'b1 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_redirect_flags got flush=%b halted=%b exp 1 1", flush, halted);
    end
    clear_inputs();
    rst = 1;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_rst_pc got %h exp 0", pc); end
    checks++; if (halted !== 1'b0 || flush !== 1'b0 || cnt !== 16'd0) begin
      errors++; $display("FAIL async_rst_state got halted=%b flush=%b cnt=%0d exp 0 0 0", halted, flush, cnt);
    end
    step();
    rst = 0;
  endtask

  task automatic test_saturation_wrap();
    jump = 1; jump_dst = 32'hFFFF_FFFC;
    for (int i = 0; i < 5; i++) step();
    checks++; if (cnt_s !== 2'd3) begin errors++; $display("FAIL sat_cnt got %0d exp 3", cnt_s); end
    checks++; if (cnt !== 16'd5) begin errors++; $display("FAIL wide_cnt got %0d exp 5", cnt); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp 0", pc_plus4); end
    jump = 0;
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", pc); end
    checks++; if (cnt_s !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", cnt_s); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_priority();
    test_stall();
    test_halt_resume();
    test_saturation_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
